// File: rtl/sonar_pkg.sv
// Shared definitions for the ultrasonic range meter: FSM state codes and
// default timing constants for a 50 MHz system clock.
package sonar_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        TRIGGER     = 4'd2,
        ESPERA_ECHO = 4'd3,
        MEDE        = 4'd4,
        ARMAZENA    = 4'd5,
        FINAL       = 4'd6,
        TIMEOUT     = 4'd7
    } estado_t;

    localparam int CLK_HZ_DEFAULT         = 50_000_000;
    localparam int TRIGGER_CYCLES_DEFAULT = 500;        // 10 us
    localparam int CM_CYCLES_DEFAULT      = 2941;       // 58.82 us per cm
    localparam int TIMEOUT_CYCLES_DEFAULT = 2_500_000;  // 50 ms

    localparam logic [11:0] BCD_MAX = 12'h999;

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD up-counter {centena, dezena, unidade} that holds at 999
// instead of wrapping, so an over-range echo reads as the maximum distance.
module contador_bcd_3dig
    import sonar_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_enable,
    output logic [11:0] o_count,
    output logic        o_saturated
);

    logic [11:0] r_count;
    logic [11:0] w_next;

    // Decimal increment with ripple carry between digits; no change at 999.
    always_comb begin
        w_next = r_count;
        if (r_count != BCD_MAX) begin
            if (r_count[3:0] != 4'd9) begin
                w_next[3:0] = r_count[3:0] + 4'd1;
            end else begin
                w_next[3:0] = 4'd0;
                if (r_count[7:4] != 4'd9) begin
                    w_next[7:4] = r_count[7:4] + 4'd1;
                end else begin
                    w_next[7:4]  = 4'd0;
                    w_next[11:8] = r_count[11:8] + 4'd1;
                end
            end
        end
    end

    // Count register: clear wins over enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= 12'h000;
        end else if (i_clear) begin
            r_count <= 12'h000;
        end else if (i_enable) begin
            r_count <= w_next;
        end
    end

    assign o_count     = r_count;
    assign o_saturated = (r_count == BCD_MAX);

endmodule

// File: rtl/sonar_medidor.sv
// Ultrasonic range meter: fires a trigger pulse, times the echo width in
// centimetres (rounded) as BCD, and flags a timeout if the echo never ends.
module sonar_medidor
    import sonar_pkg::*;
#(
    parameter int CLK_HZ         = CLK_HZ_DEFAULT,
    parameter int TRIGGER_CYCLES = TRIGGER_CYCLES_DEFAULT,
    parameter int CM_CYCLES      = CM_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int DW = (CM_CYCLES > 2) ? $clog2(CM_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] DivLast     = DW'(CM_CYCLES - 1);
    localparam logic [DW-1:0] DivHalf     = DW'(CM_CYCLES / 2);
    localparam logic [TW-1:0] TriggerLast = TW'(TRIGGER_CYCLES - 1);
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);

    if (CLK_HZ <= 0 || CM_CYCLES < 2 || TRIGGER_CYCLES < 1 ||
        TRIGGER_CYCLES >= TIMEOUT_CYCLES) begin : gParamCheck
        $error("sonar_medidor: inconsistent timing parameters");
    end

    estado_t        r_estado;
    estado_t        w_proximo;
    logic           r_echoSync1;
    logic           r_echoSync2;
    logic           r_echoPrev;
    logic [DW-1:0]  r_divisor;
    logic [TW-1:0]  r_timeout;
    logic [11:0]    r_medida;
    logic           r_erro;
    logic           w_echoRise;
    logic           w_echoFall;
    logic           w_limpa;
    logic           w_contando;
    logic           w_incrementaCm;
    logic           w_janelaTimeout;
    logic           w_timeoutHit;
    logic           w_trigger;
    logic           w_pronto;
    logic [11:0]    w_bcd;
    logic           w_bcdSat;

    assign w_echoRise      = r_echoSync2 & ~r_echoPrev;
    assign w_echoFall      = ~r_echoSync2 & r_echoPrev;
    assign w_limpa         = (r_estado == PREPARA);
    // The edge that starts MEDE already counts as the first high cycle so
    // that the echo width in cycles equals the number of divider ticks.
    assign w_contando      = ((r_estado == MEDE) && r_echoSync2) ||
                             ((r_estado == ESPERA_ECHO) && w_echoRise);
    assign w_incrementaCm  = w_contando && (r_divisor == DivHalf) && !w_bcdSat;
    assign w_janelaTimeout = (r_estado == TRIGGER) || (r_estado == ESPERA_ECHO) ||
                             (r_estado == MEDE);
    assign w_timeoutHit    = w_janelaTimeout && (r_timeout == TimeoutLast);

    contador_bcd_3dig u_contador (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_limpa),
        .i_enable    (w_incrementaCm),
        .o_count     (w_bcd),
        .o_saturated (w_bcdSat)
    );

    // Two-flop echo synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_echoSync1 <= 1'b0;
            r_echoSync2 <= 1'b0;
            r_echoPrev  <= 1'b0;
        end else begin
            r_echoSync1 <= echo;
            r_echoSync2 <= r_echoSync1;
            r_echoPrev  <= r_echoSync2;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state and Moore outputs; timeout overrides any other exit.
    always_comb begin
        w_proximo = r_estado;
        w_trigger = 1'b0;
        w_pronto  = 1'b0;
        case (r_estado)
            INICIAL: begin
                if (medir) begin
                    w_proximo = PREPARA;
                end
            end
            PREPARA: begin
                w_proximo = TRIGGER;
            end
            TRIGGER: begin
                w_trigger = 1'b1;
                if (w_timeoutHit) begin
                    w_proximo = TIMEOUT;
                end else if (r_timeout == TriggerLast) begin
                    w_proximo = ESPERA_ECHO;
                end
            end
            ESPERA_ECHO: begin
                if (w_timeoutHit) begin
                    w_proximo = TIMEOUT;
                end else if (w_echoRise) begin
                    w_proximo = MEDE;
                end
            end
            MEDE: begin
                if (w_timeoutHit) begin
                    w_proximo = TIMEOUT;
                end else if (w_echoFall) begin
                    w_proximo = ARMAZENA;
                end
            end
            ARMAZENA: begin
                w_proximo = FINAL;
            end
            FINAL: begin
                w_pronto  = 1'b1;
                w_proximo = INICIAL;
            end
            TIMEOUT: begin
                w_proximo = INICIAL;
            end
            default: begin
                w_proximo = INICIAL;
            end
        endcase
    end

    // Centimetre divider: wraps every CM_CYCLES high-echo cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_divisor <= '0;
        end else if (w_limpa) begin
            r_divisor <= '0;
        end else if (w_contando) begin
            r_divisor <= (r_divisor == DivLast) ? '0 : r_divisor + 1'b1;
        end
    end

    // Elapsed-cycle counter from trigger start; also times the trigger pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timeout <= '0;
        end else if (w_limpa) begin
            r_timeout <= '0;
        end else if (w_janelaTimeout) begin
            r_timeout <= r_timeout + 1'b1;
        end
    end

    // Result register and sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_medida <= 12'h000;
            r_erro   <= 1'b0;
        end else begin
            if (r_estado == ARMAZENA) begin
                r_medida <= w_bcd;
            end
            if (w_limpa) begin
                r_erro <= 1'b0;
            end else if (w_timeoutHit) begin
                r_erro <= 1'b1;
            end
        end
    end

    assign trigger   = w_trigger;
    assign pronto    = w_pronto;
    assign medida    = r_medida;
    assign erro      = r_erro;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_sonar_medidor.sv
// Randomized self-checking bench for sonar_medidor, run with scaled-down
// timing so whole measurements, saturation and timeout fit in a short run.
module tb_sonar_medidor;

    localparam int TRIG_T = 5;
    localparam int CM_T   = 8;
    localparam int TOUT_T = 10000;

    logic        clock;
    logic        reset;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    int          checks;
    int          errors;
    int          prontoCount;
    logic [11:0] modelMedida;

    sonar_medidor #(
        .CLK_HZ         (50_000_000),
        .TRIGGER_CYCLES (TRIG_T),
        .CM_CYCLES      (CM_T),
        .TIMEOUT_CYCLES (TOUT_T)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .echo      (echo),
        .trigger   (trigger),
        .medida    (medida),
        .pronto    (pronto),
        .erro      (erro),
        .db_estado (db_estado)
    );

    // Free-running 100 MHz clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every pronto cycle, sampled on the inactive edge.
    always @(negedge clock) begin
        if (pronto) prontoCount++;
    end

    // Distance the sensor rules promise for an echo high for h clock cycles:
    // one centimetre per CM_T cycles, rounded, held at 999.
    function automatic int cmEsperado(input int h);
        int n;
        if (h <= CM_T / 2) n = 0;
        else               n = (h - CM_T / 2 - 1) / CM_T + 1;
        if (n > 999) n = 999;
        return n;
    endfunction

    function automatic logic [11:0] toBcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic nextCycle;
        @(posedge clock);
        #1;
    endtask

    // Request a measurement and watch the whole trigger pulse.
    task automatic startMeasurement(input bit holdMedir, input bit echoEarly,
                                    input bit medirNoise);
        int n;
        int w;
        medir = 1'b1;
        nextCycle();
        if (!holdMedir) medir = 1'b0;
        n = 0;
        while (!trigger && n < 10) begin
            nextCycle();
            n++;
        end
        checkOutput("trigStart", n, 1);
        w = 0;
        while (trigger && w < 1000) begin
            if (w == 2 && echoEarly) echo = 1'b1;
            if (w == 2 && medirNoise && !holdMedir) medir = 1'b1;
            if (w == 3 && medirNoise && !holdMedir) medir = 1'b0;
            nextCycle();
            w++;
        end
        checkOutput("trigWidth", w, TRIG_T);
        if (echoEarly) begin
            repeat (30) nextCycle();
            checkOutput("esperaLevelHigh", db_estado, 3);
            echo = 1'b0;
            repeat (5) nextCycle();
        end
    endtask

    // Produce an echo of exactly 'high' cycles and check the result.
    task automatic applyStimulus(input int delay, input int high,
                                 input bit medirNoise, input bit holdMedir);
        int k;
        int pc;
        repeat (delay) nextCycle();
        echo = 1'b1;
        for (int i = 0; i < high; i++) begin
            if (medirNoise && !holdMedir && high > 4 && i == high / 2) medir = 1'b1;
            if (medirNoise && !holdMedir && high > 4 && i == high / 2 + 1) medir = 1'b0;
            nextCycle();
        end
        if (!holdMedir) medir = 1'b0;
        echo = 1'b0;
        pc = prontoCount;
        k = 0;
        while (!pronto && k < 20) begin
            nextCycle();
            k++;
        end
        checkOutput("latency", k, 4);
        modelMedida = toBcd(cmEsperado(high));
        checkOutput("medida", medida, modelMedida);
        checkOutput("erroLow", erro, 0);
        nextCycle();
        checkOutput("prontoPulses", prontoCount - pc, 1);
        checkOutput("prontoWidth", pronto, 0);
        if (!holdMedir) begin
            nextCycle();
            checkOutput("idle", db_estado, 0);
        end
    endtask

    // Measurement with no echo at all must end in the timeout path.
    task automatic runTimeout;
        int k;
        int pc;
        pc = prontoCount;
        startMeasurement(1'b0, 1'b0, 1'b0);
        k = TRIG_T;
        while (!erro && k < TOUT_T + 100) begin
            nextCycle();
            k++;
        end
        checkOutput("timeoutCycles", k, TOUT_T);
        checkOutput("timeoutState", db_estado, 7);
        checkOutput("timeoutMedida", medida, modelMedida);
        nextCycle();
        checkOutput("timeoutToIdle", db_estado, 0);
        checkOutput("erroSticky", erro, 1);
        repeat (5) nextCycle();
        checkOutput("erroHeld", erro, 1);
        checkOutput("timeoutNoPronto", prontoCount - pc, 0);
    endtask

    // Asynchronous reset in the middle of an echo aborts the measurement.
    task automatic runResetMidMeasure;
        int pc;
        pc = prontoCount;
        startMeasurement(1'b0, 1'b0, 1'b0);
        repeat (3) nextCycle();
        echo = 1'b1;
        repeat (40) nextCycle();
        checkOutput("measuring", db_estado, 4);
        #3 reset = 1'b0;
        #1;
        checkOutput("rstEstado", db_estado, 0);
        checkOutput("rstTrigger", trigger, 0);
        checkOutput("rstMedida", medida, 0);
        checkOutput("rstPronto", pronto, 0);
        checkOutput("rstErro", erro, 0);
        modelMedida = 12'h000;
        echo = 1'b0;
        repeat (3) nextCycle();
        reset = 1'b1;
        repeat (20) nextCycle();
        checkOutput("noAutoStart", db_estado, 0);
        checkOutput("rstNoPronto", prontoCount - pc, 0);
    endtask

    initial begin
        int delay;
        int high;
        bit early;
        bit noise;
        checks      = 0;
        errors      = 0;
        prontoCount = 0;
        modelMedida = 12'h000;
        reset = 1'b0;
        medir = 1'b0;
        echo  = 1'b0;
        repeat (3) nextCycle();
        checkOutput("resetEstado", db_estado, 0);
        checkOutput("resetTrigger", trigger, 0);
        checkOutput("resetMedida", medida, 0);
        checkOutput("resetPronto", pronto, 0);
        checkOutput("resetErro", erro, 0);
        reset = 1'b1;
        repeat (3) nextCycle();
        checkOutput("idleAfterReset", db_estado, 0);

        // Directed distances, including rounding and digit-carry boundaries.
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(10, 100 * CM_T, 1'b0, 1'b0);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(5, 75 * CM_T, 1'b0, 1'b0);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(5, 55 * CM_T, 1'b0, 1'b0);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(3, CM_T / 2, 1'b0, 1'b0);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(3, CM_T / 2 + 1, 1'b0, 1'b0);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(7, 99 * CM_T + CM_T / 2, 1'b0, 1'b0);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(7, 99 * CM_T + CM_T / 2 + 1, 1'b0, 1'b0);

        runTimeout();

        // Echo already high on entry, plus stray medir pulses mid-measurement.
        startMeasurement(1'b0, 1'b1, 1'b1); applyStimulus(4, 37 * CM_T, 1'b1, 1'b0);

        // medir held high: second measurement starts without a new request.
        startMeasurement(1'b1, 1'b0, 1'b0); applyStimulus(6, 12 * CM_T, 1'b0, 1'b1);
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(6, 13 * CM_T, 1'b0, 1'b0);

        // Over-range echo saturates at 999.
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(20, 1012 * CM_T + 4, 1'b0, 1'b0);

        runResetMidMeasure();
        startMeasurement(1'b0, 1'b0, 1'b0); applyStimulus(8, 21 * CM_T + 3, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            delay = $urandom_range(0, 40);
            high  = $urandom_range(1, 1700);
            early = 1'($urandom_range(0, 1));
            noise = 1'($urandom_range(0, 1));
            startMeasurement(1'b0, early, noise);
            applyStimulus(delay, high, noise, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sonar_medidor.md
SONAR_MEDIDOR -- requirements
Module: sonar_medidor

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter TRIGGER_CYCLES, default 500, trigger pulse width (10 us).
REQ-003 SHALL have parameter CM_CYCLES, default 2941, clock cycles per centimetre (58.82 us).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2_500_000, measurement timeout (50 ms).
REQ-005 SHALL have port clock  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port medir  input  1  start request, one measurement per accepted request.
REQ-008 SHALL have port echo  input  1  asynchronous echo from the ultrasonic sensor.
REQ-009 SHALL have port trigger  output  1  sensor trigger pulse.
REQ-010 SHALL have port medida  output  12  distance in cm, three BCD digits {centena, dezena, unidade}.
REQ-011 SHALL have port pronto  output  1  one-cycle pulse when medida is updated.
REQ-012 SHALL have port erro  output  1  timeout flag.
REQ-013 SHALL have port db_estado  output  4  current FSM state code.

Function
REQ-014 SHALL pass echo through a 2-flop synchronizer before any use.
REQ-015 SHALL implement states INICIAL(0), PREPARA(1), TRIGGER(2), ESPERA_ECHO(3), MEDE(4), ARMAZENA(5), FINAL(6), TIMEOUT(7).
REQ-016 INICIAL: wait for medir=1, then go to PREPARA; medir is ignored in every other state.
REQ-017 PREPARA: clear BCD counter, divider, timeout counter, and erro, for exactly one cycle, then go to TRIGGER.
REQ-018 TRIGGER: trigger=1 for exactly TRIGGER_CYCLES cycles, then go to ESPERA_ECHO; trigger=0 in all other states.
REQ-019 ESPERA_ECHO: leave on a rising edge of synchronized echo only; a level already high on entry SHALL NOT start measuring.
REQ-020 MEDE: while echo high, divider counts 0..CM_CYCLES-1 and wraps; BCD counter increments when divider equals CM_CYCLES/2 (integer), giving round-to-nearest cm.
REQ-021 MEDE: on the falling edge of synchronized echo, go to ARMAZENA.
REQ-022 BCD counter SHALL saturate at 999, with no wrap to 000.
REQ-023 ARMAZENA: load the BCD counter into the medida register, for one cycle.
REQ-024 FINAL: pronto=1 for exactly one cycle, then go to INICIAL.
REQ-025 Timeout counter runs from entry to TRIGGER until exit from MEDE; on reaching TIMEOUT_CYCLES in TRIGGER, ESPERA_ECHO or MEDE, go to TIMEOUT.
REQ-026 TIMEOUT: set erro=1, leave medida unchanged, no pronto, then go to INICIAL next cycle.
REQ-027 erro SHALL stay set until the next PREPARA.
REQ-028 Latency from echo falling edge to pronto SHALL be synchronizer delay (2) plus 2 cycles, i.e. 4 cycles.
REQ-029 medir held high continuously SHALL start back-to-back measurements, each through FINAL or TIMEOUT.

Reset
REQ-030 While reset=0, regardless of state, SHALL drive the FSM to INICIAL, trigger=0, medida=12'h000, pronto=0, erro=0, all counters 0, synchronizer flops 0, db_estado=4'h0.
REQ-031 Reset asserted mid-measurement SHALL abort it with no pronto; the first measurement after release requires medir.

Structure
REQ-032 State codes and default CM_CYCLES, TRIGGER_CYCLES, TIMEOUT_CYCLES SHALL live in shared package sonar_pkg.
REQ-033 The saturating 3-digit BCD counter SHALL be sub-module contador_bcd_3dig (clear, enable, 12-bit output, saturation flag).
REQ-034 The FSM and the datapath (synchronizer, divider, timeout counter, medida register) SHALL be in sonar_medidor.

Verification
REQ-035 medir pulse, echo high 5882 us starting 400 us after trigger -> trigger high exactly 500 cycles; medida=12'h100; single pronto.
REQ-036 Echo 4430 us -> medida=12'h075; echo 3222 us -> medida=12'h055; each with exactly one pronto.
REQ-037 No echo after medir -> erro=1 at 2_500_000 cycles after trigger rise; medida retains previous value; no pronto.
REQ-038 Echo 60 ms (>999 cm equivalent, timeout disabled via TIMEOUT_CYCLES override) -> medida=12'h999.
REQ-039 reset=0 during MEDE -> outputs at reset values immediately (asynchronous); no pronto; next medir gives correct measurement.
REQ-040 medir pulses during TRIGGER/MEDE -> ignored; echo already high on ESPERA_ECHO entry -> no measurement until a fresh rising edge.
